rambus_arbiter: RTL and testbench

RAMBUS_ARBITER -- requirements
Module: rambus_arbiter

---
 rtl/rambus_arbiter.sv | 149 ++++++++++++++
 tb/tb_rambus_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rambus_arbiter.sv
// Two-port round-robin arbiter that funnels APB-style requests from two
// requesters onto a single strobe/ack register bus, with a per-transfer
// timeout that completes the transfer with an error flag.
module rambus_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nRst,

    input  logic              Sel0,
    input  logic              Enable0,
    input  logic              Write0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    output logic              Ready0,
    output logic [DATA_W-1:0] RData0,
    output logic              SlvErr0,

    input  logic              Sel1,
    input  logic              Enable1,
    input  logic              Write1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ready1,
    output logic [DATA_W-1:0] RData1,
    output logic              SlvErr1,

    output logic              BusStb,
    output logic              BusWrnRd,
    output logic [ADDR_W-1:0] BusAddr,
    output logic [DATA_W-1:0] BusDataOut,
    input  logic [DATA_W-1:0] BusDataIn,
    input  logic              BusAck
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arbState_t;

    // Counter is wide enough for the largest supported TIMEOUT (1023).
    localparam int                CNT_W       = 10;
    localparam logic [CNT_W-1:0]  TIMEOUT_END = CNT_W'(TIMEOUT - 1);

    arbState_t           state;
    logic                lastServed;
    logic                grantIdx;
    logic [CNT_W-1:0]    waitCnt;
    logic                errFlag;
    logic [DATA_W-1:0]   capData;
    logic                readyQ0;
    logic                readyQ1;

    logic                pend0;
    logic                pend1;
    logic                nextGrant;

    // A requester is pending while in its access phase and not yet completed.
    assign pend0 = Sel0 & Enable0 & ~Ready0;
    assign pend1 = Sel1 & Enable1 & ~Ready1;

    // Round-robin choice: a tie goes to whichever requester was not served last.
    always_comb begin
        nextGrant = 1'b0;
        if (pend0 && pend1) begin
            nextGrant = ~lastServed;
        end else if (pend1) begin
            nextGrant = 1'b1;
        end
    end

    // Completion pulse is withdrawn if the granted requester drops Sel during
    // DONE; read data and error are only presented alongside a visible Ready.
    assign Ready0  = readyQ0 & Sel0;
    assign Ready1  = readyQ1 & Sel1;
    assign RData0  = Ready0 ? capData : '0;
    assign RData1  = Ready1 ? capData : '0;
    assign SlvErr0 = Ready0 & errFlag;
    assign SlvErr1 = Ready1 & errFlag;

    // Transfer sequencer: grant, strobe, wait for ack or timeout, complete.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state      <= IDLE;
            lastServed <= 1'b1;
            grantIdx   <= 1'b0;
            waitCnt    <= '0;
            errFlag    <= 1'b0;
            capData    <= '0;
            readyQ0    <= 1'b0;
            readyQ1    <= 1'b0;
            BusStb     <= 1'b0;
            BusWrnRd   <= 1'b0;
            BusAddr    <= '0;
            BusDataOut <= '0;
        end else begin
            BusStb  <= 1'b0;
            readyQ0 <= 1'b0;
            readyQ1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend0 || pend1) begin
                        grantIdx   <= nextGrant;
                        BusWrnRd   <= nextGrant ? Write1 : Write0;
                        BusAddr    <= nextGrant ? Addr1  : Addr0;
                        BusDataOut <= nextGrant ? WData1 : WData0;
                        BusStb     <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    waitCnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (BusAck) begin
                        // An ack on the final counted cycle still wins over timeout.
                        capData <= BusWrnRd ? '0 : BusDataIn;
                        errFlag <= 1'b0;
                        readyQ0 <= ~grantIdx;
                        readyQ1 <= grantIdx;
                        state   <= DONE;
                    end else if (waitCnt == TIMEOUT_END) begin
                        waitCnt <= waitCnt + CNT_W'(1);
                        capData <= '0;
                        errFlag <= 1'b1;
                        readyQ0 <= ~grantIdx;
                        readyQ1 <= grantIdx;
                        state   <= DONE;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    lastServed <= grantIdx;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rambus_arbiter.sv
// Directed bench for rambus_arbiter: single transfers, ties, round-robin,
// timeout, requester abort and mid-transfer reset.
module tb_rambus_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic              clk;
    logic              nRst;
    logic              Sel0, Enable0, Write0;
    logic [ADDR_W-1:0] Addr0;
    logic [DATA_W-1:0] WData0;
    logic              Ready0;
    logic [DATA_W-1:0] RData0;
    logic              SlvErr0;
    logic              Sel1, Enable1, Write1;
    logic [ADDR_W-1:0] Addr1;
    logic [DATA_W-1:0] WData1;
    logic              Ready1;
    logic [DATA_W-1:0] RData1;
    logic              SlvErr1;
    logic              BusStb;
    logic              BusWrnRd;
    logic [ADDR_W-1:0] BusAddr;
    logic [DATA_W-1:0] BusDataOut;
    logic [DATA_W-1:0] BusDataIn;
    logic              BusAck;

    int vecs = 0;
    int errs = 0;

    rambus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
        .clk(clk), .nRst(nRst),
        .Sel0(Sel0), .Enable0(Enable0), .Write0(Write0), .Addr0(Addr0), .WData0(WData0),
        .Ready0(Ready0), .RData0(RData0), .SlvErr0(SlvErr0),
        .Sel1(Sel1), .Enable1(Enable1), .Write1(Write1), .Addr1(Addr1), .WData1(WData1),
        .Ready1(Ready1), .RData1(RData1), .SlvErr1(SlvErr1),
        .BusStb(BusStb), .BusWrnRd(BusWrnRd), .BusAddr(BusAddr), .BusDataOut(BusDataOut),
        .BusDataIn(BusDataIn), .BusAck(BusAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    int          expG [6] = '{0, 1, 0, 1, 0, 1};
    int          g;
    logic [31:0] expAddr;

    initial begin
        nRst = 1'b0;
        Sel0 = 0; Enable0 = 0; Write0 = 0; Addr0 = '0; WData0 = '0;
        Sel1 = 0; Enable1 = 0; Write1 = 0; Addr1 = '0; WData1 = '0;
        BusAck = 0; BusDataIn = '0;
        tick();
        tick();
        // Reset values
        chk1("rst_stb", BusStb, 1'b0);
        chk1("rst_wrnrd", BusWrnRd, 1'b0);
        chk32("rst_addr", 32'(BusAddr), 32'h0);
        chk32("rst_dout", BusDataOut, 32'h0);
        chk1("rst_rdy0", Ready0, 1'b0);
        chk1("rst_rdy1", Ready1, 1'b0);
        chk32("rst_rdata0", RData0, 32'h0);
        chk1("rst_err1", SlvErr1, 1'b0);
        nRst = 1'b1;
        tick();

        // Port-0 read of 0x0010, ack two cycles after the strobe
        Sel0 = 1; Enable0 = 1; Write0 = 0; Addr0 = 14'h0010;
        tick();
        chk1("t1_stb", BusStb, 1'b1);
        chk32("t1_addr", 32'(BusAddr), 32'h0010);
        chk1("t1_wrnrd", BusWrnRd, 1'b0);
        chk1("t1_rdy_early", Ready0, 1'b0);
        tick();
        chk1("t1_stb_once", BusStb, 1'b0);
        tick();
        BusAck = 1; BusDataIn = 32'h12345678;
        tick();
        BusAck = 0;
        chk1("t1_rdy0", Ready0, 1'b1);
        chk32("t1_rdata0", RData0, 32'h12345678);
        chk1("t1_err0", SlvErr0, 1'b0);
        chk1("t1_rdy1", Ready1, 1'b0);
        chk32("t1_rdata1", RData1, 32'h0);
        Sel0 = 0; Enable0 = 0;
        tick();
        chk1("t1_rdy0_off", Ready0, 1'b0);
        chk1("t1_idle_stb", BusStb, 1'b0);

        // Reset so last-served returns to 1, then a same-cycle tie
        nRst = 1'b0;
        tick();
        nRst = 1'b1;
        Sel0 = 1; Enable0 = 1; Write0 = 1; Addr0 = 14'h0004; WData0 = 32'hA5A5A5A5;
        Sel1 = 1; Enable1 = 1; Write1 = 0; Addr1 = 14'h0008;
        tick();
        chk1("t2_stb_a", BusStb, 1'b1);
        chk32("t2_addr_a", 32'(BusAddr), 32'h0004);
        chk1("t2_wrnrd_a", BusWrnRd, 1'b1);
        chk32("t2_dout_a", BusDataOut, 32'hA5A5A5A5);
        tick();
        BusAck = 1; BusDataIn = 32'hDEADBEEF;
        tick();
        BusAck = 0;
        chk1("t2_rdy0", Ready0, 1'b1);
        chk32("t2_rdata0_wr", RData0, 32'h0);
        chk1("t2_rdy1_wait", Ready1, 1'b0);
        Sel0 = 0; Enable0 = 0;
        tick();
        chk1("t2_idle_stb", BusStb, 1'b0);
        tick();
        chk1("t2_stb_b", BusStb, 1'b1);
        chk32("t2_addr_b", 32'(BusAddr), 32'h0008);
        chk1("t2_wrnrd_b", BusWrnRd, 1'b0);
        tick();
        BusAck = 1; BusDataIn = 32'hCAFEF00D;
        tick();
        BusAck = 0;
        chk1("t2_rdy1", Ready1, 1'b1);
        chk32("t2_rdata1", RData1, 32'hCAFEF00D);
        chk1("t2_rdy0_off", Ready0, 1'b0);
        chk32("t2_rdata0_ng", RData0, 32'h0);
        Sel1 = 0; Enable1 = 0;
        tick();
        chk1("t2_rdy1_off", Ready1, 1'b0);

        // Three rounds of back-to-back ties
        Sel0 = 1; Enable0 = 1; Write0 = 0;
        Sel1 = 1; Enable1 = 1; Write1 = 0;
        for (int k = 0; k < 6; k++) begin
            g = expG[k];
            Addr0 = 14'h0100 + 14'(k);
            Addr1 = 14'h0200 + 14'(k);
            expAddr = (g == 0) ? (32'h0100 + 32'(k)) : (32'h0200 + 32'(k));
            tick();
            chk1("t3_stb", BusStb, 1'b1);
            chk32("t3_grant_addr", 32'(BusAddr), expAddr);
            tick();
            BusAck = 1; BusDataIn = 32'h1000 + 32'(k);
            tick();
            BusAck = 0;
            chk1("t3_rdy_win", (g == 0) ? Ready0 : Ready1, 1'b1);
            chk1("t3_rdy_lose", (g == 0) ? Ready1 : Ready0, 1'b0);
            chk32("t3_rdata", (g == 0) ? RData0 : RData1, 32'h1000 + 32'(k));
            if (k == 5) begin
                Sel0 = 0; Enable0 = 0; Sel1 = 0; Enable1 = 0;
            end
            tick();
        end
        chk1("t3_end_stb", BusStb, 1'b0);

        // Timeout with TIMEOUT = 8: Ready appears 8 cycles after WAIT entry
        Sel0 = 1; Enable0 = 1; Write0 = 0; Addr0 = 14'h0020;
        tick();
        chk1("t4_stb", BusStb, 1'b1);
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk1("t4_rdy_w7", Ready0, 1'b0);
        tick();
        chk1("t4_rdy_to", Ready0, 1'b1);
        chk1("t4_err_to", SlvErr0, 1'b1);
        chk32("t4_rdata_to", RData0, 32'h0);
        Sel0 = 0; Enable0 = 0;
        tick();
        chk1("t4_rdy_off", Ready0, 1'b0);
        Sel0 = 1; Enable0 = 1; Addr0 = 14'h0024;
        tick();
        tick();
        BusAck = 1; BusDataIn = 32'h000055AA;
        tick();
        BusAck = 0;
        chk1("t4_rdy_ok", Ready0, 1'b1);
        chk1("t4_err_ok", SlvErr0, 1'b0);
        chk32("t4_rdata_ok", RData0, 32'h000055AA);
        Sel0 = 0; Enable0 = 0;
        tick();

        // Ack on the last counted WAIT cycle is a success
        Sel1 = 1; Enable1 = 1; Write1 = 0; Addr1 = 14'h0028;
        tick();
        tick();
        for (int i = 0; i < 7; i++) tick();
        BusAck = 1; BusDataIn = 32'h00000077;
        tick();
        BusAck = 0;
        chk1("t4c_rdy1", Ready1, 1'b1);
        chk1("t4c_err1", SlvErr1, 1'b0);
        chk32("t4c_rdata1", RData1, 32'h00000077);
        Sel1 = 0; Enable1 = 0;
        tick();

        // Requester 0 aborts during WAIT; requester 1 is served next
        Sel0 = 1; Enable0 = 1; Write0 = 0; Addr0 = 14'h0030;
        Sel1 = 1; Enable1 = 1; Write1 = 0; Addr1 = 14'h0034;
        tick();
        chk32("t5_addr0", 32'(BusAddr), 32'h0030);
        tick();
        Sel0 = 0; Enable0 = 0;
        BusAck = 1; BusDataIn = 32'h00000099;
        tick();
        BusAck = 0;
        chk1("t5_rdy0_abort", Ready0, 1'b0);
        chk1("t5_rdy1_wait", Ready1, 1'b0);
        tick();
        chk1("t5_idle_stb", BusStb, 1'b0);
        tick();
        chk1("t5_stb1", BusStb, 1'b1);
        chk32("t5_addr1", 32'(BusAddr), 32'h0034);
        tick();
        BusAck = 1; BusDataIn = 32'h00000066;
        tick();
        BusAck = 0;
        chk1("t5_rdy1", Ready1, 1'b1);
        chk32("t5_rdata1", RData1, 32'h00000066);
        Sel1 = 0; Enable1 = 0;
        tick();

        // One-cycle reset during WAIT, then a late ack
        Sel1 = 1; Enable1 = 1; Write1 = 1; Addr1 = 14'h0040; WData1 = 32'h01020304;
        tick();
        chk1("t6_stb", BusStb, 1'b1);
        tick();
        nRst = 1'b0;
        tick();
        nRst = 1'b1;
        chk1("t6_stb_rst", BusStb, 1'b0);
        chk32("t6_addr_rst", 32'(BusAddr), 32'h0);
        chk1("t6_wrnrd_rst", BusWrnRd, 1'b0);
        chk32("t6_dout_rst", BusDataOut, 32'h0);
        chk1("t6_rdy1_rst", Ready1, 1'b0);
        chk32("t6_rdata1_rst", RData1, 32'h0);
        chk1("t6_err1_rst", SlvErr1, 1'b0);
        Sel1 = 0; Enable1 = 0;
        BusAck = 1; BusDataIn = 32'h00000BAD;
        tick();
        BusAck = 0;
        chk1("t6_late_rdy1", Ready1, 1'b0);
        chk1("t6_late_stb", BusStb, 1'b0);
        tick();
        chk1("t6_late_rdy1b", Ready1, 1'b0);
        chk1("t6_late_rdy0", Ready0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
